serial_negate_ctrl: RTL and testbench



---
 rtl/serial_negate_pkg.sv | 24 ++
 rtl/serial_twos_comp_core.sv | 38 +++
 rtl/serial_negate_ctrl.sv | 133 +++++++++++++
 tb/tb_serial_negate_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_negate_pkg.sv
// Shared types and constants for the bit-serial negation sequencer and its core.
package serial_negate_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } ctrl_state_e;

  typedef enum logic [1:0] {
    S0 = 2'd0,  // no 1 seen yet
    S1 = 2'd1,  // first 1 just seen
    S2 = 2'd2,  // after first 1, last input 0
    S3 = 2'd3   // after first 1, last input 1
  } core_state_e;

  // Moore output per core state, indexed by state encoding: S0=0 S1=1 S2=1 S3=0
  localparam logic [3:0] CORE_OUT_LUT = 4'b0110;

  function automatic logic core_out_of(input core_state_e s);
    return CORE_OUT_LUT[s];
  endfunction

endpackage

// File: rtl/serial_twos_comp_core.sv
// Bit-serial two's-complement Moore core: LSB-first input, output depends on state only.
// Bits up to and including the first 1 pass through; later bits are inverted.
module serial_twos_comp_core
  import serial_negate_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       a,
  output logic       out,
  output logic [1:0] state
);

  core_state_e state_q, state_d;

  // Next-state: clr wins over a; S1/S2/S3 all track the last input bit
  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = S0;
    end else begin
      case (state_q)
        S0:      state_d = a ? S1 : S0;
        default: state_d = a ? S3 : S2;
      endcase
    end
  end

  // State register, asynchronous reset to S0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S0;
    else       state_q <= state_d;
  end

  assign out   = core_out_of(state_q);
  assign state = state_q;

endmodule

// File: rtl/serial_negate_ctrl.sv
// Sequencer for the bit-serial negation core: latches a parallel word on start,
// feeds it LSB-first into the core, collects the serial result and pulses done.
// Optional macro SERIAL_NEGATE_STATUS_EN adds registered zero/ovf status outputs.
module serial_negate_ctrl
  import serial_negate_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dout,
  output logic [1:0]       core_state
`ifdef SERIAL_NEGATE_STATUS_EN
  ,
  output logic             zero,
  output logic             ovf
`endif
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);

  ctrl_state_e      state_q, state_d;
  logic [WIDTH-1:0] op_sr_q, op_sr_d;
  logic [WIDTH-1:0] res_sr_q, res_sr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             core_clr;
  logic             ser_a;
  logic             core_out;

`ifdef SERIAL_NEGATE_STATUS_EN
  logic op_msb_q, op_msb_d;
  logic zero_q, zero_d;
  logic ovf_q, ovf_d;
`endif

  serial_twos_comp_core u_core (
    .clk   (clk),
    .reset (reset),
    .clr   (core_clr),
    .a     (ser_a),
    .out   (core_out),
    .state (core_state)
  );

  // Controller next-state and datapath updates
  always_comb begin
    state_d  = state_q;
    op_sr_d  = op_sr_q;
    res_sr_d = res_sr_q;
    cnt_d    = cnt_q;
    dout_d   = dout_q;
    core_clr = 1'b0;
    ser_a    = 1'b0;
`ifdef SERIAL_NEGATE_STATUS_EN
    op_msb_d = op_msb_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          op_sr_d  = din;
          res_sr_d = '0;
          cnt_d    = '0;
          core_clr = 1'b1;
          state_d  = SHIFT;
`ifdef SERIAL_NEGATE_STATUS_EN
          op_msb_d = din[WIDTH-1];
`endif
        end
      end
      SHIFT: begin
        ser_a   = (cnt_q < CNT_LAST) ? op_sr_q[0] : 1'b0;
        op_sr_d = op_sr_q >> 1;
        cnt_d   = cnt_q + CNT_W'(1);
        // Core output lags its input by one cycle, so nothing useful at count 0
        if (cnt_q != '0) res_sr_d = {core_out, res_sr_q[WIDTH-1:1]};
        if (cnt_q == CNT_LAST) begin
          dout_d  = res_sr_d;
          state_d = DONE;
`ifdef SERIAL_NEGATE_STATUS_EN
          zero_d  = (res_sr_d == '0);
          ovf_d   = op_msb_q & res_sr_d[WIDTH-1];
`endif
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Controller and datapath registers, asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      op_sr_q  <= '0;
      res_sr_q <= '0;
      cnt_q    <= '0;
      dout_q   <= '0;
`ifdef SERIAL_NEGATE_STATUS_EN
      op_msb_q <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      op_sr_q  <= op_sr_d;
      res_sr_q <= res_sr_d;
      cnt_q    <= cnt_d;
      dout_q   <= dout_d;
`ifdef SERIAL_NEGATE_STATUS_EN
      op_msb_q <= op_msb_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);
  assign dout = dout_q;
`ifdef SERIAL_NEGATE_STATUS_EN
  assign zero = zero_q;
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_negate_ctrl.sv
// Self-checking bench for serial_negate_ctrl (WIDTH=8); expected results come from
// plain modulo-256 negation. Status checks are compiled when SERIAL_NEGATE_STATUS_EN is set.
module tb_serial_negate_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         reset;
  logic         start;
  logic [W-1:0] din;
  logic         busy;
  logic         done;
  logic [W-1:0] dout;
  logic [1:0]   core_state;
`ifdef SERIAL_NEGATE_STATUS_EN
  logic         zero;
  logic         ovf;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  serial_negate_ctrl #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .din        (din),
    .busy       (busy),
    .done       (done),
    .dout       (dout),
    .core_state (core_state)
`ifdef SERIAL_NEGATE_STATUS_EN
    ,
    .zero       (zero),
    .ovf        (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W-1:0] neg_model(input logic [W-1:0] v);
    int r;
    r = (256 - int'(v)) % 256;
    return r[W-1:0];
  endfunction

  // Issues one start (at the next negedge = cycle 0) and watches until done.
  // Reports done cycle (-1 on timeout), busy-profile errors and early dout changes.
  task automatic run_op(input logic [W-1:0] d, output int done_cyc, output int busy_err,
                        output int dout_err, output int done_abs);
    logic [W-1:0] held;
    done_cyc = -1; busy_err = 0; dout_err = 0; done_abs = -1;
    @(negedge clk);
    start = 1'b1; din = d;
    held = dout;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      start = 1'b0;
      din = W'($urandom);
      if (done) begin
        done_cyc = c; done_abs = cyc;
        if (busy) busy_err++;
        break;
      end
      if (busy !== 1'b1) busy_err++;
      if (dout !== held) dout_err++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; din = '0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy, done, dout, core_state} !== {1'b0, 1'b0, 8'h00, 2'd0}) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b done=%b dout=%h core=%0d, want 0 0 00 0",
               busy, done, dout, core_state);
    end
`ifdef SERIAL_NEGATE_STATUS_EN
    n_checks++;
    if ({zero, ovf} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_status: zero=%b ovf=%b, want 0 0", zero, ovf);
    end
`endif
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed;
    logic [W-1:0] vals [4] = '{8'h05, 8'h00, 8'h80, 8'h01};
    int dc, be, de, da;
    for (int i = 0; i < 4; i++) begin
      run_op(vals[i], dc, be, de, da);
      n_checks++;
      if (dc !== 10 || be !== 0 || de !== 0) begin
        n_fail++;
        $display("FAIL dir_timing[%h]: done_cyc=%0d busy_err=%0d dout_err=%0d, want 10 0 0",
                 vals[i], dc, be, de);
      end
      n_checks++;
      if (dout !== neg_model(vals[i])) begin
        n_fail++;
        $display("FAIL dir_dout[%h]: got %h want %h", vals[i], dout, neg_model(vals[i]));
      end
`ifdef SERIAL_NEGATE_STATUS_EN
      n_checks++;
      if (zero !== (neg_model(vals[i]) == 0) ||
          ovf !== (vals[i][W-1] & neg_model(vals[i])[W-1])) begin
        n_fail++;
        $display("FAIL dir_status[%h]: zero=%b ovf=%b", vals[i], zero, ovf);
      end
`endif
      @(negedge clk);
    end
  endtask

  task automatic test_ignored_start;
    int ndone, dcyc;
    ndone = 0; dcyc = -1;
    @(negedge clk);
    start = 1'b1; din = 8'h03;
    for (int c = 1; c <= 25; c++) begin
      @(negedge clk);
      if (done) begin ndone++; if (dcyc < 0) dcyc = c; end
      start = (c == 3 || c == 10) ? 1'b1 : 1'b0;
      din = (c == 3 || c == 10) ? 8'h7F : 8'h00;
    end
    start = 1'b0;
    n_checks++;
    if (ndone !== 1 || dcyc !== 10) begin
      n_fail++;
      $display("FAIL ignored_start: dones=%0d first=%0d, want 1 at 10", ndone, dcyc);
    end
    n_checks++;
    if (dout !== 8'hFD) begin
      n_fail++;
      $display("FAIL ignored_dout: got %h want fd", dout);
    end
  endtask

  task automatic test_reset_mid_op;
    int ndone, dc, be, de, da;
    ndone = 0;
    @(negedge clk);
    start = 1'b1; din = 8'h5A;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    @(negedge clk);  // cycle 5
    reset = 1'b1;
    #1;
    n_checks++;
    if ({busy, done, dout, core_state} !== {1'b0, 1'b0, 8'h00, 2'd0}) begin
      n_fail++;
      $display("FAIL midop_reset: busy=%b done=%b dout=%h core=%0d, want 0 0 00 0",
               busy, done, dout, core_state);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    n_checks++;
    if (ndone !== 0) begin
      n_fail++;
      $display("FAIL midop_no_done: activity cycles=%0d want 0", ndone);
    end
    run_op(8'h10, dc, be, de, da);
    n_checks++;
    if (dc !== 10 || dout !== 8'hF0) begin
      n_fail++;
      $display("FAIL after_reset_op: done_cyc=%0d dout=%h, want 10 f0", dc, dout);
    end
  endtask

  task automatic test_back_to_back;
    int dc1, dc2, be, de, da1, da2;
    run_op(8'h01, dc1, be, de, da1);
    n_checks++;
    if (dout !== 8'hFF) begin
      n_fail++;
      $display("FAIL b2b_first: got %h want ff", dout);
    end
    run_op(8'hFE, dc2, be, de, da2);
    n_checks++;
    if (dout !== 8'h02 || (da2 - da1) !== 11 || da1 < 0 || da2 < 0) begin
      n_fail++;
      $display("FAIL b2b_second: dout=%h gap=%0d, want 02 11", dout, da2 - da1);
    end
    @(negedge clk);
  endtask

  task automatic test_random;
    logic [W-1:0] d;
    int dc, be, de, da;
    for (int i = 0; i < 20; i++) begin
      d = W'($urandom);
      run_op(d, dc, be, de, da);
      n_checks++;
      if (dout !== neg_model(d) || dc !== 10 || be !== 0 || de !== 0) begin
        n_fail++;
        $display("FAIL rand[%0d] din=%h: dout=%h want %h done_cyc=%0d busy_err=%0d dout_err=%0d",
                 i, d, dout, neg_model(d), dc, be, de);
      end
`ifdef SERIAL_NEGATE_STATUS_EN
      n_checks++;
      if (zero !== (neg_model(d) == 0) || ovf !== (d[W-1] & neg_model(d)[W-1])) begin
        n_fail++;
        $display("FAIL rand_status[%0d] din=%h: zero=%b ovf=%b", i, d, zero, ovf);
      end
`endif
      // random idle gap, sometimes zero for back-to-back issue
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_ignored_start;
    test_reset_mid_op;
    test_back_to_back;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
